media_seq: RTL and testbench

Upstream sample sequencer for the `media` averager. It buffers incoming bytes from a ready/valid source in a small FIFO. Once a full batch of `N` samples is present, it issues `start`, then presents the samples one by one as single-cycle `valid` pulses with idle gaps between them. It then waits for the averager's `done`, captures `media` into a registered result, and returns to idle for the next batch.

---
 rtl/media_seq.sv | 155 +++++++++++++++
 tb/tb_media_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/media_seq.sv
// media_seq: FIFO-buffered batch sequencer feeding the media averager.
// Optional watchdog on the WAIT state is enabled by MEDIA_SEQ_TIMEOUT_EN.
module media_seq #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter int N       = 4,
  parameter int GAP     = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  output logic                       avg_start,
  output logic [WIDTH-1:0]           avg_data,
  output logic                       avg_valid,
  input  logic                       avg_done,
  input  logic [WIDTH-1:0]           avg_media,
  output logic [WIDTH-1:0]           result,
  output logic                       result_valid,
  output logic                       busy,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int LW = $clog2(N+1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_FEED, S_GAP, S_WAIT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [LW-1:0]    r_left;
  logic [3:0]       r_gap;
  logic [WIDTH-1:0] r_avg_data;
  logic [WIDTH-1:0] r_result;
  logic             r_result_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_done;
  logic             w_timeout;

  assign s_ready      = (r_count != CW'(DEPTH));
  assign w_push       = s_valid & s_ready;
  assign w_done       = (r_state == S_WAIT) & avg_done;
  assign count        = r_count;
  assign avg_data     = r_avg_data;
  assign result       = r_result;
  assign result_valid = r_result_valid;

`ifdef MEDIA_SEQ_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT+1) > 8) ? $clog2(TIMEOUT+1) : 8;
  logic [TW-1:0] r_wdog;
  logic          r_err;

  assign w_timeout = (r_state == S_WAIT) & ~avg_done &
                     (r_wdog == TW'(TIMEOUT-1));
  assign err = r_err;

  // Watchdog counts WAIT cycles; err latches until reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      r_wdog <= (r_state == S_WAIT) ? r_wdog + 1'b1 : '0;
      r_err  <= r_err | w_timeout;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  // Sample storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= s_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (r_count >= CW'(N)) w_next = S_START;
      S_START: w_next = S_FEED;
      S_FEED: begin
        if (r_left == '0)  w_next = S_WAIT;
        else if (GAP == 0) w_next = S_FEED;
        else               w_next = S_GAP;
      end
      S_GAP:   if (r_gap == '0) w_next = S_FEED;
      S_WAIT:  if (avg_done || w_timeout) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Moore outputs; a pop accompanies every entry into FEED
  always_comb begin
    avg_start = (r_state == S_START);
    avg_valid = (r_state == S_FEED);
    busy      = (r_state != S_IDLE);
    w_pop     = (w_next == S_FEED);
  end

  // Batch counters, presented sample and captured result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_left         <= '0;
      r_gap          <= '0;
      r_avg_data     <= '0;
      r_result       <= '0;
      r_result_valid <= 1'b0;
    end else begin
      if (avg_start)  r_left <= LW'(N-1);
      else if (w_pop) r_left <= r_left - 1'b1;
      if (r_state == S_FEED)     r_gap <= 4'(GAP-1);
      else if (r_state == S_GAP) r_gap <= r_gap - 1'b1;
      if (w_pop)  r_avg_data <= r_mem[r_rptr];
      if (w_done) r_result   <= avg_media;
      r_result_valid <= w_done;
    end
  end

endmodule

// File: tb/tb_media_seq.sv
// tb_media_seq: directed bench for media_seq with a behavioural averager.
// Averager model samples DUT outputs 2 time units after each rising edge.
module tb_media_seq;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       avg_start;
  logic [7:0] avg_data;
  logic       avg_valid;
  logic       avg_done;
  logic [7:0] avg_media;
  logic [7:0] result;
  logic       result_valid;
  logic       busy;
  logic [3:0] count;
  logic       err;

  media_seq #(.WIDTH(8), .DEPTH(8), .N(4), .GAP(1), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .avg_start(avg_start), .avg_data(avg_data), .avg_valid(avg_valid),
    .avg_done(avg_done), .avg_media(avg_media),
    .result(result), .result_valid(result_valid),
    .busy(busy), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cnt = 0;
  int valid_cnt = 0;
  int rv_cnt = 0;
  int nb = 0;
  int acc = 0;
  bit pend = 0;
  bit suppress = 0;
  int smp [64];
  int vt [64];
  int res [32];
  int e1 [4] = '{24, 32, 10, 14};
  int b, r0, s0, c0, g;
  bit pre, pp, seen;

  // Behavioural averager: done one cycle after the N-th sample
  initial begin
    avg_done  = 1'b0;
    avg_media = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      avg_done = 1'b0;
      if (!reset) begin
        pend = 0; nb = 0; acc = 0;
      end else begin
        if (pend && !suppress) begin
          avg_done = 1'b1; avg_media = 8'(acc / 4); pend = 0;
        end
        if (avg_start) begin
          start_cnt++; acc = 0; nb = 0;
        end
        if (avg_valid) begin
          smp[valid_cnt] = int'(avg_data);
          vt[valid_cnt]  = cyc;
          valid_cnt++;
          acc += int'(avg_data);
          nb++;
          if (nb == 4) begin pend = 1; nb = 0; end
        end
        if (result_valid) begin
          res[rv_cnt] = int'(result); rv_cnt++;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] x);
    s_data = x; s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int tgt);
    int k = 0;
    while (valid_cnt < tgt && k < 300) begin @(negedge clk); k++; end
    chk("wait_valid", 32'(valid_cnt >= tgt), 1);
  endtask

  task automatic wait_rv(input int tgt);
    int k = 0;
    while (rv_cnt < tgt && k < 300) begin @(negedge clk); k++; end
    chk("wait_rv", 32'(rv_cnt >= tgt), 1);
  endtask

  initial begin
    reset = 1'b0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_start", avg_start, 0);
    chk("rst_valid", avg_valid, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    chk("rst_data", avg_data, 0);
    chk("rst_result", result, 0);
    chk("rst_ready", s_ready, 1);
    reset = 1'b1;
    @(negedge clk);

    // basic batch 24,32,10,14
    b = valid_cnt; r0 = rv_cnt; s0 = start_cnt;
    push(24); push(32); push(10); push(14);
    chk("t1_count4", count, 4);
    chk("t1_nostart", avg_start, 0);
    @(negedge clk);
    chk("t1_start", avg_start, 1);
    chk("t1_busy", busy, 1);
    @(negedge clk);
    chk("t1_v0", avg_valid, 1);
    chk("t1_d0", avg_data, 24);
    chk("t1_count3", count, 3);
    @(negedge clk);
    chk("t1_gap", avg_valid, 0);
    chk("t1_hold", avg_data, 24);
    @(negedge clk);
    chk("t1_v1", avg_valid, 1);
    chk("t1_d1", avg_data, 32);
    wait_rv(r0 + 1);
    chk("t1_rvpulse", result_valid, 1);
    chk("t1_result", result, 20);
    chk("t1_idle", busy, 0);
    @(negedge clk);
    chk("t1_rvlow", result_valid, 0);
    chk("t1_nstart", start_cnt - s0, 1);
    chk("t1_nvalid", valid_cnt - b, 4);
    for (int i = 0; i < 4; i++) chk("t1_sample", smp[b+i], e1[i]);
    for (int i = 0; i < 3; i++) chk("t1_spacing", vt[b+i+1] - vt[b+i], 2);

    // three samples do not start a batch; the fourth does
    b = valid_cnt; r0 = rv_cnt; s0 = start_cnt;
    push(1); push(2); push(3);
    repeat (5) @(negedge clk);
    chk("t2_busy", busy, 0);
    chk("t2_nostart", start_cnt - s0, 0);
    chk("t2_count3", count, 3);
    push(4);
    chk("t2_pre", avg_start, 0);
    @(negedge clk);
    chk("t2_start", avg_start, 1);
    wait_rv(r0 + 1);
    chk("t2_result", result, 2);

    // fill FIFO while a batch waits for done
    b = valid_cnt; r0 = rv_cnt;
    suppress = 1;
    push(40); push(40); push(40); push(40);
    wait_valid(b + 4);
    s_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_data = 8'(i + 1);
      @(negedge clk);
    end
    chk("t3_full", count, 8);
    chk("t3_notready", s_ready, 0);
    s_data = 8'd99;
    @(negedge clk);
    chk("t3_refused", count, 8);
    chk("t3_notready2", s_ready, 0);
    chk("t3_waiting", busy, 1);
    s_valid = 1'b0;
    suppress = 0;
    wait_rv(r0 + 3);
    chk("t3_res_a", res[r0], 40);
    chk("t3_res_b1", res[r0+1], 2);
    chk("t3_res_b2", res[r0+2], 6);
    chk("t3_nvalid", valid_cnt - b, 12);
    for (int i = 0; i < 8; i++) chk("t3_order", smp[b+4+i], i + 1);
    chk("t3_empty", count, 0);

    // streaming push with concurrent pops keeps order
    b = valid_cnt; r0 = rv_cnt; seen = 0; pp = 0;
    for (int i = 1; i <= 12; i++) begin
      s_data = 8'(i); s_valid = 1'b1; g = 0;
      do begin
        pre = s_ready;
        if (avg_start && pre) begin c0 = int'(count); pp = 1; end
        @(negedge clk);
        if (pp) begin
          chk("t4_pushpop", count, c0); seen = 1; pp = 0;
        end
        g++;
      end while (!pre && g < 50);
    end
    s_valid = 1'b0;
    chk("t4_seen", seen, 1);
    wait_rv(r0 + 3);
    chk("t4_res0", res[r0], 2);
    chk("t4_res1", res[r0+1], 6);
    chk("t4_res2", res[r0+2], 10);
    for (int i = 0; i < 12; i++) chk("t4_order", smp[b+i], i + 1);

    // asynchronous reset during GAP
    push(50); push(60); push(70); push(80);
    @(negedge clk);
    @(negedge clk);
    chk("t5_feed", avg_valid, 1);
    @(negedge clk);
    chk("t5_gap", avg_valid, 0);
    chk("t5_busy", busy, 1);
    chk("t5_count3", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_r_busy", busy, 0);
    chk("t5_r_count", count, 0);
    chk("t5_r_valid", avg_valid, 0);
    chk("t5_r_start", avg_start, 0);
    chk("t5_r_data", avg_data, 0);
    chk("t5_r_result", result, 0);
    chk("t5_r_rv", result_valid, 0);
    chk("t5_r_ready", s_ready, 1);
    chk("t5_r_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    r0 = rv_cnt;
    push(5); push(5); push(5); push(5);
    wait_rv(r0 + 1);
    chk("t5_result", result, 5);
    repeat (3) @(negedge clk);
    chk("t5_onepulse", rv_cnt - r0, 1);

`ifdef MEDIA_SEQ_TIMEOUT_EN
    // watchdog expiry in WAIT
    suppress = 1;
    b = valid_cnt; r0 = rv_cnt;
    push(1); push(1); push(1); push(1);
    wait_valid(b + 4);
    repeat (20) @(negedge clk);
    chk("t6_before", err, 0);
    @(negedge clk);
    chk("t6_err", err, 1);
    chk("t6_idle", busy, 0);
    repeat (3) @(negedge clk);
    chk("t6_norv", rv_cnt - r0, 0);
    chk("t6_sticky", err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
